uart_tx: RTL and testbench

Serial transmitter that sits directly upstream of the UART receiver in the UART subsystem. Accepts one parallel byte with a single-cycle `Data_Valid` strobe and serialises it onto `TX_OUT`:
- frame: start bit, 8 data bits LSB first, optional parity bit, stop bit;
- bit period: each bit is held for `Prescale` clock cycles, so the line format is bit-compatible with the receiver's `PAR_EN`/`PAR_TYP`/`Prescale` configuration.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_baud_cnt.sv | 30 +++
 rtl/uart_tx.sv | 154 +++++++++++++++
 tb/tb_uart_tx.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, parity types and default widths
// used by both the transmitter and the receiver.
package uart_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int PRESC_W_DEF = 6;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic PAR_XOR  = 1'b0;
    localparam logic PAR_XNOR = 1'b1;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts clk cycles within one bit and pulses bit_done
// on the last cycle of the period. A prescale of 0 behaves like 1.
module uart_baud_cnt #(
    parameter int PRESC_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic [PRESC_W-1:0] prescale,
    output logic               bit_done
);

    logic [PRESC_W-1:0] count_reg;
    logic [PRESC_W-1:0] limit;

    assign limit    = (prescale == '0) ? '0 : prescale - PRESC_W'(1);
    assign bit_done = (count_reg == limit);

    // Restarting on bit_done makes every bit start from zero without a gap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (clear || bit_done) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_W data bits LSB first, optional parity,
// stop bit, each held Prescale cycles. TX_OUT and busy come straight from flops.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int PRESC_W = PRESC_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  P_DATA,
    input  logic               Data_Valid,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    input  logic [PRESC_W-1:0] Prescale,
    output logic               TX_OUT,
    output logic               busy
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_START  = START;
    localparam logic [2:0] ST_DATA   = DATA;
    localparam logic [2:0] ST_PARITY = PARITY;
    localparam logic [2:0] ST_STOP   = STOP;

    logic [2:0]         state_reg, state_next;
    logic [DATA_W-1:0]  data_reg;
    logic               par_en_reg;
    logic               par_typ_reg;
    logic [PRESC_W-1:0] presc_reg;
    logic [IDX_W-1:0]   idx_reg, idx_next, idx_inc;
    logic               tx_reg, tx_next;
    logic               busy_reg, busy_next;
    logic               load;
    logic               bit_done;
    logic               cnt_clear;
    logic               par_bit;
    logic [DATA_W:0]    par_chain;

    // Parity always comes from the latched byte, never from live P_DATA.
    assign par_chain[0] = 1'b0;
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_par
            assign par_chain[gi+1] = par_chain[gi] ^ data_reg[gi];
        end
    endgenerate
    assign par_bit = (par_typ_reg == PAR_XNOR) ? ~par_chain[DATA_W] : par_chain[DATA_W];

    assign idx_inc   = idx_reg + IDX_W'(1);
    assign cnt_clear = (state_reg == ST_IDLE);

    uart_baud_cnt #(
        .PRESC_W (PRESC_W)
    ) u_baud_cnt (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear),
        .prescale (presc_reg),
        .bit_done (bit_done)
    );

    // Next line value is decided together with the next state so TX_OUT
    // changes on exactly the edge that starts the new bit.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        tx_next    = tx_reg;
        busy_next  = busy_reg;
        load       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                tx_next   = 1'b1;
                busy_next = 1'b0;
                if (Data_Valid) begin
                    load       = 1'b1;
                    state_next = ST_START;
                    tx_next    = 1'b0;
                    busy_next  = 1'b1;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_next = ST_DATA;
                    idx_next   = '0;
                    tx_next    = data_reg[0];
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    if (idx_reg == IDX_W'(DATA_W - 1)) begin
                        if (par_en_reg) begin
                            state_next = ST_PARITY;
                            tx_next    = par_bit;
                        end else begin
                            state_next = ST_STOP;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        idx_next = idx_inc;
                        tx_next  = data_reg[idx_inc];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    state_next = ST_STOP;
                    tx_next    = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    state_next = ST_IDLE;
                    tx_next    = 1'b1;
                    busy_next  = 1'b0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                tx_next    = 1'b1;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            idx_reg     <= '0;
            tx_reg      <= 1'b1;
            busy_reg    <= 1'b0;
            data_reg    <= '0;
            par_en_reg  <= 1'b0;
            par_typ_reg <= 1'b0;
            presc_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            tx_reg    <= tx_next;
            busy_reg  <= busy_next;
            if (load) begin
                data_reg    <= P_DATA;
                par_en_reg  <= PAR_EN;
                par_typ_reg <= PAR_TYP;
                presc_reg   <= Prescale;
            end
        end
    end

    assign TX_OUT = tx_reg;
    assign busy   = busy_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: checks every line cycle of each frame against
// hand-built bit patterns and decodes the line with a simple receiver model.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] P_DATA = 8'h00;
    logic       Data_Valid = 1'b1;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [5:0] Prescale = 6'd0;
    logic       TX_OUT;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx #(
        .DATA_W  (8),
        .PRESC_W (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_tx"}, {31'd0, TX_OUT}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    // Entered and left at a falling edge. exp_par is the hand-computed parity bit.
    // inject >= 0: at that frame cycle, scramble inputs and raise Data_Valid once.
    task automatic send_frame(input string name, input logic [7:0] d, input logic pen,
                              input logic ptyp, input logic [5:0] presc, input logic exp_par,
                              input int inject, input int idle_after);
        int p, nbits, bad, c;
        logic [10:0] bits;
        logic [10:0] line;
        logic [7:0] rx_data;
        logic par_err, stop_err;
        p = (presc == 6'd0) ? 1 : int'(presc);
        nbits = pen ? 11 : 10;
        bits = '1;
        bits[0] = 1'b0;
        for (int j = 0; j < 8; j++) bits[1+j] = d[j];
        if (pen) bits[9] = exp_par;
        line = '1;

        P_DATA = d;
        PAR_EN = pen;
        PAR_TYP = ptyp;
        Prescale = presc;
        Data_Valid = 1'b1;
        @(posedge clk);
        for (int b = 0; b < nbits; b++) begin
            bad = 0;
            for (int s = 0; s < p; s++) begin
                @(negedge clk);
                c = b * p + s;
                Data_Valid = (c == inject);
                if (c == inject) begin
                    P_DATA = 8'h00;
                    PAR_EN = ~pen;
                    PAR_TYP = ~ptyp;
                    Prescale = 6'd1;
                end
                if (TX_OUT !== bits[b] || busy !== 1'b1) bad++;
                if (s == p / 2) line[b] = TX_OUT;
            end
            check($sformatf("%s_bit%0d_bad_cycles", name, b), bad, 0);
        end
        @(negedge clk);
        Data_Valid = 1'b0;
        check_idle({name, "_end"});
        for (int i = 0; i < idle_after; i++) begin
            @(negedge clk);
            check_idle({name, "_after"});
        end

        for (int j = 0; j < 8; j++) rx_data[j] = line[1+j];
        par_err = pen && (line[9] !== (ptyp ? ~^rx_data : ^rx_data));
        stop_err = (line[nbits-1] !== 1'b1);
        check({name, "_rx_data"}, {24'd0, rx_data}, {24'd0, d});
        check({name, "_rx_par_error"}, {31'd0, par_err}, 32'd0);
        check({name, "_rx_stop_error"}, {31'd0, stop_err}, 32'd0);
        $display("tx %s data=%02h par_en=%0d par_typ=%0d prescale=%0d cycles=%0d rx=%02h",
                 name, d, pen, ptyp, presc, nbits * p, rx_data);
    endtask

    initial begin
        // Reset held with Data_Valid high: line must stay idle.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("reset_hold");
        end
        rst = 1'b1;
        Data_Valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("post_reset");
        end
        $display("tx reset released, line idle");

        send_frame("f45", 8'h45, 1'b0, 1'b0, 6'd8, 1'b0, -1, 2);
        send_frame("fAA", 8'hAA, 1'b1, 1'b1, 6'd8, 1'b1, -1, 2);
        send_frame("fA8", 8'hA8, 1'b1, 1'b0, 6'd16, 1'b1, 60, 4);
        // Data_Valid on the edge where busy falls must be ignored.
        send_frame("f45_lastedge", 8'h45, 1'b0, 1'b0, 6'd3, 1'b0, 29, 3);
        send_frame("fFF_p0", 8'hFF, 1'b0, 1'b0, 6'd0, 1'b0, -1, 0);
        send_frame("f00_p0", 8'h00, 1'b0, 1'b0, 6'd0, 1'b0, -1, 2);
        send_frame("f01_p1", 8'h01, 1'b1, 1'b0, 6'd1, 1'b1, -1, 1);

        // Reset in the middle of a start bit returns the line high at once.
        P_DATA = 8'h45;
        PAR_EN = 1'b0;
        Prescale = 6'd8;
        Data_Valid = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            Data_Valid = 1'b0;
        end
        check("midreset_before_tx", {31'd0, TX_OUT}, 32'd0);
        check("midreset_before_busy", {31'd0, busy}, 32'd1);
        #2 rst = 1'b0;
        #1 check_idle("midreset_async");
        @(negedge clk);
        check_idle("midreset_hold");
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("midreset_release");
        end
        $display("tx midreset aborted frame, line idle");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
